rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit arbitrated multiplexer with a registered output.
- Next generation of the team's 2:1 byte mux. Selection is no longer an external sel input: the block arbitrates between valid/ready requesters.
- Each accepted word is passed through one pipeline register stage.
- Used wherever several producers (e.g. fetch/LSU/debug) share a single downstream consumer.

Parameters:
- WIDTH, 8, data width per channel in bits.
- N, 4, number of input channels (N >= 2).
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
- SELW, $clog2(N), width of the channel-index output (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel request.
- in_ready  output  N  per-channel accept, one-hot or zero.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer=0, so channel 0 has highest priority.
  - in_ready=0 while rst_n is low.
  - Reset asserted mid-transfer drops the held word. No partial state survives.
- Handshake:
  - A transfer occurs on a rising edge where valid && ready.
  - Producers hold in_valid and in_data stable until accepted.
  - While out_valid && !out_ready, out_data and out_sel are held stable.
- load_en = !out_valid || out_ready, i.e. the register is empty or draining this cycle.
- Arbitration (combinational, same cycle):
  - If load_en and any in_valid is set, exactly one grant bit is set and in_ready = grant.
  - Otherwise in_ready = 0.
- Fixed-priority mode (RR=0): grant the lowest-index valid channel. The pointer is unused and stays 0.
- Round-robin mode (RR=1):
  - Search starts at the pointer and wraps modulo N; the first valid channel wins.
  - After a grant to channel k: pointer <= (k+1) mod N. Wrap-around: k=N-1 gives pointer 0.
  - The pointer is unchanged on cycles with no grant.
- On a grant to channel k at edge t:
  - out_data <= in_data[k], out_sel <= k, out_valid <= 1.
  - The word is visible from edge t.
  - Latency is 1 cycle from acceptance to out_valid.
- If load_en is true and no channel is valid: out_valid <= 0. out_data and out_sel keep their last value.
- Simultaneous drain and load (out_valid && out_ready with a new grant): the old word leaves and the new word loads on the same edge. Sustained throughput is 1 word/cycle with no bubble.
- Full stall (out_valid && !out_ready): all in_ready=0, the pointer is frozen, and no request is lost.
- Channels with in_valid=0 are never granted. in_ready is never asserted for more than one channel.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with out_valid=1. Required: out_valid, out_data and out_sel go to 0 immediately, without a clock edge. After release with all in_valid=0, out_valid stays 0.
- Single channel, WIDTH=8, N=4, RR=1, out_ready=1:
  - Stimulus: in_valid=4'b0100 with ch2 data 8'hA5.
  - Required: in_ready=4'b0100. Next edge gives out_data=8'hA5, out_sel=2, out_valid=1. Pointer becomes 3.
- Round-robin fairness:
  - Stimulus: all four channels valid continuously (data 8'h10, 8'h21, 8'h32, 8'h43), out_ready=1, starting from reset.
  - Required: out_sel sequence 0,1,2,3,0,… with matching data. One word per cycle, no gaps.
- Fixed priority:
  - Stimulus: RR=0, in_valid=4'b1010 held for 3 cycles.
  - Required: channel 1 is granted every cycle and out_sel=1 throughout. Channel 3 is never granted until channel 1 drops.
- Backpressure:
  - Stimulus: word from ch3 (8'h5A) loaded, then out_ready=0 for 4 cycles with ch0 valid.
  - Required: out_data=8'h5A and out_sel=3 stable, in_ready=0. ch0 is granted on the first cycle out_ready=1. Pointer wrap 3→0 is observed.
- Drain to empty: single word, then in_valid=0 with out_ready=1. Required: out_valid drops after one cycle. out_data retains the last value.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel valid/ready arbitrated multiplexer with one registered output stage.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0) selection.
module rr_arb_mux #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N     = 4,
  parameter  int unsigned RR    = 1,
  localparam int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] words [N];
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  search_base;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  ptr_nxt;
  logic [N-1:0]     grant;
  logic             load_en;
  logic             any_valid;
  logic             take;

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign words[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // First requester found when scanning upward from start, wrapping modulo N.
  function automatic logic [SELW-1:0] first_from(input logic [N-1:0]    req,
                                                 input logic [SELW-1:0] start);
    logic [SELW-1:0] idx;
    logic            found;
    int unsigned     k;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      k = (32'(start) + off) % N;
      if (!found && req[SELW'(k)]) begin
        idx   = SELW'(k);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign load_en     = !out_valid || out_ready;
  assign any_valid   = |in_valid;
  assign take        = load_en && any_valid;
  assign search_base = (RR != 0) ? ptr : '0;
  assign ptr_nxt     = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    grant   = '0;
    gnt_idx = first_from(in_valid, search_base);
    if (take) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // Accept is suppressed outright while reset is held.
  assign in_ready = grant & {N{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= words[gnt_idx];
        out_sel   <= gnt_idx;
        if (RR != 0) begin
          ptr <= ptr_nxt;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
